hbus_ram_responder: RTL and testbench

- Synthesizable HyperBus memory responder: the device end of the HyperBus link driven by the OpenHBMC controller.
- Used as an on-chip HyperRAM stand-in for loopback tests and for sims without a vendor model.
- Oversamples the bus on a single system clock running at 2x the HyperBus CK rate, so every CK transition is detectable.
- Decodes the 48-bit command/address, applies fixed latency and serves linear read/write bursts from an internal RAM plus a small register space.

---
 rtl/hbus_ram_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_hbus_ram_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hbus_ram_responder.sv
// hbus_ram_responder
// Device end of a HyperBus link: an on-chip HyperRAM stand-in for loopback
// and controller simulations. The bus is oversampled on clk, which runs at
// twice the CK rate, so every CK transition is visible as one clk-long event.
//
// Ports:
//   clk, rst        system clock (2x CK) and asynchronous active-high reset
//   hb_reset_n      bus reset, active low; synchronous soft reset of FSM/CR0
//   hb_cs_n, hb_ck  chip select and bus clock (CK is sampled as data)
//   hb_dq_i/o/oe    DQ bus in / out / output enable
//   hb_rwds_i       RWDS from the bus (write byte mask)
//   hb_rwds_o/oe    RWDS driven: latency indicator in CA, read strobe in data
//   cmd_err         one-clk pulse on a register write to an undefined register
//   dbg_state       current FSM state (enum encoding of state_t)
//
// Transfer protocol: with hb_cs_n low, every change of hb_ck relative to its
// value on the previous clk (ev) transfers exactly one byte, in either
// direction. There is no back-pressure; CS# low with no ev freezes the FSM.
module hbus_ram_responder #(
  parameter int          ADDR_W     = 10,
  parameter int          LATENCY    = 6,
  parameter int          DOUBLE_LAT = 1,
  parameter logic [15:0] ID0_VAL    = 16'h0C81,
  parameter logic [15:0] ID1_VAL    = 16'h0001,
  parameter logic [15:0] CR0_RST    = 16'h8F1F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hb_reset_n,
  input  logic       hb_cs_n,
  input  logic       hb_ck,
  input  logic [7:0] hb_dq_i,
  output logic [7:0] hb_dq_o,
  output logic       hb_dq_oe,
  input  logic       hb_rwds_i,
  output logic       hb_rwds_o,
  output logic       hb_rwds_oe,
  output logic       cmd_err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_LAT   = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_REGW  = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  // Latency in CK edges; each CK cycle has two edges.
  localparam int          LAT_EV   = 2 * LATENCY * (DOUBLE_LAT + 1);
  localparam logic [15:0] LAT_LAST = 16'(LAT_EV - 1);
  localparam logic        RWDS_LAT = (DOUBLE_LAT != 0);
  localparam logic [11:0] CR0_ADDR = 12'h800;

  // Registers
  state_t              state, state_n;
  logic                ck_q, cs_q;
  logic [15:0]         cnt, cnt_n;
  logic [39:0]         sh, sh_n;           // first five CA bytes
  logic                rd_q, rd_q_n;
  logic                reg_q, reg_q_n;
  logic [11:0]         reg_addr_q, reg_addr_q_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic                byte_sel, byte_sel_n; // 0 = upper byte of word next
  logic [7:0]          regw_hi, regw_hi_n;
  logic [15:0]         cr0, cr0_n;
  logic [7:0]          dq_o_n;
  logic                dq_oe_n, rwds_o_n, rwds_oe_n, cmd_err_n;

  // RAM
  logic [15:0]         mem [0:(1<<ADDR_W)-1];
  logic [15:0]         rd_word;
  logic                mem_we_hi, mem_we_lo;

  // Decode helpers
  logic                ev;
  logic [47:0]         ca_full;
  logic [31:0]         full_addr;
  logic [15:0]         reg_rdata;
  logic [15:0]         rd_data;
  logic                unused_ca_bits;

  assign ev        = (hb_ck != ck_q) & ~hb_cs_n;
  assign ca_full   = {sh, hb_dq_i};
  assign full_addr = {ca_full[44:16], ca_full[2:0]};
  // CA[45] (burst type) and the reserved field do not affect behaviour.
  assign unused_ca_bits = ^{ca_full[45], ca_full[15:3]};
  assign dbg_state = state;

  always_comb begin
    case (reg_addr_q)
      12'h000:  reg_rdata = ID0_VAL;
      12'h001:  reg_rdata = ID1_VAL;
      CR0_ADDR: reg_rdata = cr0;
      default:  reg_rdata = 16'h0000;
    endcase
  end

  // Register reads repeat the same word for the whole burst.
  assign rd_data = reg_q ? reg_rdata : rd_word;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sh_n         = sh;
    rd_q_n       = rd_q;
    reg_q_n      = reg_q;
    reg_addr_q_n = reg_addr_q;
    addr_n       = addr;
    byte_sel_n   = byte_sel;
    regw_hi_n    = regw_hi;
    cr0_n        = cr0;
    dq_o_n       = hb_dq_o;
    dq_oe_n      = hb_dq_oe;
    rwds_o_n     = hb_rwds_o;
    rwds_oe_n    = hb_rwds_oe;
    cmd_err_n    = 1'b0;
    mem_we_hi    = 1'b0;
    mem_we_lo    = 1'b0;

    if (!hb_reset_n) begin
      state_n   = S_IDLE;
      cr0_n     = CR0_RST;
      dq_o_n    = 8'h00;
      dq_oe_n   = 1'b0;
      rwds_o_n  = 1'b0;
      rwds_oe_n = 1'b0;
    end else if (hb_cs_n) begin
      state_n   = S_IDLE;
      dq_o_n    = 8'h00;
      dq_oe_n   = 1'b0;
      rwds_o_n  = 1'b0;
      rwds_oe_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Only a fresh CS# falling edge starts a transaction; a soft reset
          // taken with CS# still low waits here for the next one.
          if (cs_q) begin
            state_n   = S_CA;
            cnt_n     = 16'd0;
            rwds_oe_n = 1'b1;
            rwds_o_n  = RWDS_LAT;
          end
        end
        S_CA: begin
          rwds_oe_n = 1'b1;
          rwds_o_n  = RWDS_LAT;
          if (ev) begin
            sh_n  = {sh[31:0], hb_dq_i};
            cnt_n = cnt + 16'd1;
            if (cnt == 16'd5) begin
              cnt_n        = 16'd0;
              byte_sel_n   = 1'b0;
              rd_q_n       = ca_full[47];
              reg_q_n      = ca_full[46];
              reg_addr_q_n = full_addr[11:0];
              addr_n       = full_addr[ADDR_W-1:0];
              rwds_oe_n    = 1'b0;
              rwds_o_n     = 1'b0;
              state_n      = (!ca_full[47] && ca_full[46]) ? S_REGW : S_LAT;
            end
          end
        end
        S_LAT: begin
          if (ev) begin
            cnt_n = cnt + 16'd1;
            if (cnt == LAT_LAST) begin
              cnt_n   = 16'd0;
              state_n = rd_q ? S_RDATA : S_WDATA;
            end
          end
        end
        S_WDATA: begin
          // Bytes go straight into the RAM lanes, so an aborted burst keeps
          // everything already transferred, including a lone upper byte.
          if (ev) begin
            byte_sel_n = ~byte_sel;
            if (!hb_rwds_i) begin
              mem_we_hi = ~byte_sel;
              mem_we_lo = byte_sel;
            end
            if (byte_sel) addr_n = addr + ADDR_W'(1);
          end
        end
        S_RDATA: begin
          if (ev) begin
            dq_oe_n    = 1'b1;
            rwds_oe_n  = 1'b1;
            rwds_o_n   = hb_ck;
            dq_o_n     = byte_sel ? rd_data[7:0] : rd_data[15:8];
            byte_sel_n = ~byte_sel;
            if (byte_sel) addr_n = addr + ADDR_W'(1);
          end
        end
        S_REGW: begin
          if (ev) begin
            byte_sel_n = ~byte_sel;
            if (!byte_sel) begin
              regw_hi_n = hb_dq_i;
            end else begin
              if (reg_addr_q == CR0_ADDR) cr0_n = {regw_hi, hb_dq_i};
              else                        cmd_err_n = 1'b1;
              state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          state_n = S_HOLD;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ck_q       <= 1'b0;
      cs_q       <= 1'b1;
      cnt        <= 16'd0;
      sh         <= 40'd0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      reg_addr_q <= 12'd0;
      addr       <= '0;
      byte_sel   <= 1'b0;
      regw_hi    <= 8'h00;
      cr0        <= CR0_RST;
      hb_dq_o    <= 8'h00;
      hb_dq_oe   <= 1'b0;
      hb_rwds_o  <= 1'b0;
      hb_rwds_oe <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      ck_q       <= hb_ck;
      cs_q       <= hb_cs_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      rd_q       <= rd_q_n;
      reg_q      <= reg_q_n;
      reg_addr_q <= reg_addr_q_n;
      addr       <= addr_n;
      byte_sel   <= byte_sel_n;
      regw_hi    <= regw_hi_n;
      cr0        <= cr0_n;
      hb_dq_o    <= dq_o_n;
      hb_dq_oe   <= dq_oe_n;
      hb_rwds_o  <= rwds_o_n;
      hb_rwds_oe <= rwds_oe_n;
      cmd_err    <= cmd_err_n;
    end
  end

  // Read port is addressed with the next address so the following word is
  // already registered when the first byte of it is requested, even with an
  // ev on every clk.
  always_ff @(posedge clk) begin
    if (mem_we_hi) mem[addr][15:8] <= hb_dq_i;
    if (mem_we_lo) mem[addr][7:0]  <= hb_dq_i;
    rd_word <= mem[addr_n];
  end

endmodule

// File: tb/tb_hbus_ram_responder.sv
// Directed bench for hbus_ram_responder (defaults: ADDR_W=10, LATENCY=6,
// DOUBLE_LAT=1, so 24 latency edges). CK toggles once per clk (full rate).
module tb_hbus_ram_responder;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CA    = 3'd1;
  localparam logic [2:0] S_LAT   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_REGW  = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  logic       clk, rst, hb_reset_n, hb_cs_n, hb_ck;
  logic [7:0] hb_dq_i, hb_dq_o;
  logic       hb_dq_oe, hb_rwds_i, hb_rwds_o, hb_rwds_oe, cmd_err;
  logic [2:0] dbg_state;

  int n_err;
  int n_checks;
  logic [7:0] exp_q[$];
  logic [8:0] wr_q[$];   // {mask, byte}

  hbus_ram_responder dut (
    .clk        (clk),
    .rst        (rst),
    .hb_reset_n (hb_reset_n),
    .hb_cs_n    (hb_cs_n),
    .hb_ck      (hb_ck),
    .hb_dq_i    (hb_dq_i),
    .hb_dq_o    (hb_dq_o),
    .hb_dq_oe   (hb_dq_oe),
    .hb_rwds_i  (hb_rwds_i),
    .hb_rwds_o  (hb_rwds_o),
    .hb_rwds_oe (hb_rwds_oe),
    .cmd_err    (cmd_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ck_edge(input logic [7:0] d, input logic m);
    hb_ck     = ~hb_ck;
    hb_dq_i   = d;
    hb_rwds_i = m;
    step();
  endtask

  task automatic cmd(input logic rd, input logic rs, input logic [31:0] wa, input logic [2:0] st);
    logic [47:0] ca;
    ca = {rd, rs, 1'b0, wa[31:3], 13'd0, wa[2:0]};
    hb_cs_n = 1'b0;
    step();
    check("ca_rwds", 32'({hb_rwds_oe, hb_rwds_o}), 32'h3);
    for (int i = 0; i < 6; i++) ck_edge(ca[47-8*i -: 8], 1'b0);
    check("ca_rwds_drop", 32'(hb_rwds_oe), 32'h0);
    check("ca_state", 32'(dbg_state), 32'(st));
  endtask

  task automatic latency();
    for (int i = 0; i < 24; i++) ck_edge(8'h00, 1'b0);
  endtask

  task automatic end_xfer();
    hb_cs_n   = 1'b1;
    hb_ck     = 1'b0;
    hb_rwds_i = 1'b0;
    step();
    check("idle_oe", 32'({hb_dq_oe, hb_rwds_oe}), 32'h0);
    check("idle_state", 32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic push_w(input logic [15:0] w, input logic mhi, input logic mlo);
    wr_q.push_back({mhi, w[15:8]});
    wr_q.push_back({mlo, w[7:0]});
  endtask

  task automatic push_e(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic write_xfer(input logic [31:0] wa);
    logic [8:0] b;
    cmd(1'b0, 1'b0, wa, S_LAT);
    latency();
    check("wr_state", 32'(dbg_state), 32'(S_WDATA));
    while (wr_q.size() > 0) begin
      b = wr_q.pop_front();
      ck_edge(b[7:0], b[8]);
      check("wr_dq_oe", 32'(hb_dq_oe), 32'h0);
    end
    end_xfer();
  endtask

  task automatic read_xfer(input logic rs, input logic [31:0] wa, input int nbytes);
    logic [7:0] e;
    cmd(1'b1, rs, wa, S_LAT);
    latency();
    for (int i = 0; i < nbytes; i++) begin
      ck_edge(8'h00, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("rd_dq", 32'(hb_dq_o), 32'(e));
      check("rd_rwds", 32'(hb_rwds_o), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("rd_oe", 32'({hb_dq_oe, hb_rwds_oe}), 32'h3);
    end
    end_xfer();
  endtask

  task automatic reg_write(input logic [31:0] wa, input logic [15:0] v, input logic err);
    cmd(1'b0, 1'b1, wa, S_REGW);
    ck_edge(v[15:8], 1'b0);
    check("regw_err_early", 32'(cmd_err), 32'h0);
    ck_edge(v[7:0], 1'b0);
    check("regw_err", 32'(cmd_err), 32'(err));
    check("regw_state", 32'(dbg_state), 32'(S_HOLD));
    step();
    check("regw_err_pulse", 32'(cmd_err), 32'h0);
    end_xfer();
  endtask

  // Stimulus and scoreboard
  initial begin
    n_err = 0;
    n_checks = 0;
    rst = 1'b1;
    hb_reset_n = 1'b1;
    hb_cs_n = 1'b1;
    hb_ck = 1'b0;
    hb_dq_i = 8'h00;
    hb_rwds_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_outs", 32'({hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe, cmd_err}), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // rst pulse in the middle of CA
    hb_cs_n = 1'b0;
    step();
    check("mid_ca_state", 32'(dbg_state), 32'(S_CA));
    ck_edge(8'hC0, 1'b0);
    ck_edge(8'h00, 1'b0);
    ck_edge(8'h00, 1'b0);
    rst = 1'b1;
    step();
    check("midca_rst_outs", 32'({hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe, cmd_err}), 32'h0);
    check("midca_rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    hb_cs_n = 1'b1;
    hb_ck = 1'b0;
    step();

    // ID registers; the word repeats for the rest of the burst
    push_e(16'h0C81); push_e(16'h0C81);
    read_xfer(1'b1, 32'h000, 4);
    push_e(16'h0001);
    read_xfer(1'b1, 32'h001, 2);

    // Known old contents at 0x012, then masked burst at 0x010
    push_w(16'hABCD, 1'b0, 1'b0);
    write_xfer(32'h012);
    push_w(16'h1111, 1'b0, 1'b0);
    push_w(16'h2222, 1'b0, 1'b0);
    push_w(16'h3333, 1'b1, 1'b0);
    push_w(16'h4444, 1'b0, 1'b0);
    write_xfer(32'h010);
    push_e(16'h1111); push_e(16'h2222); push_e(16'hAB33); push_e(16'h4444);
    read_xfer(1'b0, 32'h010, 8);

    // Address wrap at the top of RAM
    push_w(16'h1234, 1'b0, 1'b0);
    push_w(16'h5678, 1'b0, 1'b0);
    write_xfer(32'h3FF);
    push_e(16'h1234); push_e(16'h5678);
    read_xfer(1'b0, 32'h3FF, 4);
    push_e(16'h5678);
    read_xfer(1'b0, 32'h000, 2);

    // CR0 write, undefined register write, undefined register read
    reg_write(32'h800, 16'h8F17, 1'b0);
    push_e(16'h8F17);
    read_xfer(1'b1, 32'h800, 2);
    reg_write(32'h123, 16'hBEEF, 1'b1);
    push_e(16'h8F17);
    read_xfer(1'b1, 32'h800, 2);
    push_e(16'h0000);
    read_xfer(1'b1, 32'h123, 2);

    // Abort a write after three data bytes
    push_w(16'h0102, 1'b0, 1'b0);
    push_w(16'h0304, 1'b0, 1'b0);
    write_xfer(32'h020);
    wr_q.push_back({1'b0, 8'hAA});
    wr_q.push_back({1'b0, 8'hBB});
    wr_q.push_back({1'b0, 8'hCC});
    write_xfer(32'h020);
    push_e(16'hAABB); push_e(16'hCC04);
    read_xfer(1'b0, 32'h020, 4);

    // hb_reset_n low for 2 clk in the middle of a CR0 read
    cmd(1'b1, 1'b1, 32'h800, S_LAT);
    latency();
    ck_edge(8'h00, 1'b0);
    check("hr_byte0", 32'({hb_dq_oe, hb_dq_o}), 32'h18F);
    ck_edge(8'h00, 1'b0);
    check("hr_byte1", 32'({hb_dq_oe, hb_dq_o}), 32'h117);
    hb_reset_n = 1'b0;
    step();
    check("hr_oe", 32'({hb_dq_oe, hb_rwds_oe}), 32'h0);
    check("hr_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    hb_reset_n = 1'b1;
    end_xfer();
    push_e(16'h8F1F);
    read_xfer(1'b1, 32'h800, 2);
    push_e(16'h1111); push_e(16'h2222);
    read_xfer(1'b0, 32'h010, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
